// File: rtl/uart_rx_feed.sv
// -----------------------------------------------------------------------------
// uart_rx_feed
//
// Receives bytes from an RS-232 line and packs pairs of them into 16-bit words
// for an SDRAM write FIFO. The first valid byte of a pair is the low byte and
// the second is the high byte. Every completed word raises a one-cycle write
// strobe, and the SDRAM word address then advances by one. Once WORD_CNT words
// have been written, WR_DONE stays high until reset. Bytes that arrive after
// that point are still received, but they produce no strobe.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      serial bit rate (BAUD_DIV = CLK_FREQ / BAUD, truncated)
//   WORD_CNT  number of 16-bit words to accept before WR_DONE
//
// Ports
//   SYSCLK        rising-edge clock for all logic
//   RST           synchronous active-high reset
//   RS232_RX      asynchronous serial input, idle high
//   WR_FIFO_DATA  last assembled word (held between strobes)
//   WR_FIFO_REQ   one-cycle write strobe for WR_FIFO_DATA
//   WR_ADDR       SDRAM word address of the current word (wraps at 2^22)
//   WR_DONE       level, WORD_CNT words written
//   FRAME_ERR     one-cycle pulse on a low stop bit
//   PAR_ERR       one-cycle pulse on an even-parity mismatch
//
// Build option
//   UART_RX_PARITY_EN  when defined, the frame is 8E1 and PAR_ERR is live.
//                      Otherwise the frame is 8N1 and PAR_ERR is tied to 0.
// -----------------------------------------------------------------------------
module uart_rx_feed #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int WORD_CNT = 256
) (
    input  logic        SYSCLK,
    input  logic        RST,
    input  logic        RS232_RX,
    output logic [15:0] WR_FIFO_DATA,
    output logic        WR_FIFO_REQ,
    output logic [21:0] WR_ADDR,
    output logic        WR_DONE,
    output logic        FRAME_ERR,
    output logic        PAR_ERR
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int WC_W     = $clog2(WORD_CNT + 1);

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(WORD_CNT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_reg, state_next;
    logic               rx_meta_reg, rx_sync_reg;
    logic               armed_reg, armed_next;
    logic [CNT_W-1:0]   baud_cnt_reg, baud_cnt_next;
    logic [2:0]         bit_cnt_reg, bit_cnt_next;
    logic [7:0]         shift_reg, shift_next;
    logic               par_bad_reg;
    logic               byte_ok, byte_bad, par_fail;

    logic               pending_reg;
    logic [7:0]         low_byte_reg;
    logic [15:0]        data_reg;
    logic               req_reg;
    logic [21:0]        addr_reg;
    logic [WC_W-1:0]    word_cnt_reg;
    logic               done_reg;
    logic               frame_err_reg;

    // Receive FSM: next state, bit timing and the per-byte verdicts
    always_comb begin
        state_next    = state_reg;
        armed_next    = armed_reg;
        baud_cnt_next = baud_cnt_reg + 1'b1;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        byte_ok       = 1'b0;
        byte_bad      = 1'b0;
        par_fail      = 1'b0;

        case (state_reg)
            IDLE: begin
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                // A start bit is recognized only after the line has been
                // seen high. This way, a line stuck low cannot retrigger
                // reception over and over.
                if (rx_sync_reg) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    armed_next = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt_reg == HALF_LAST) begin
                    baud_cnt_next = '0;
                    // A line that is high again at mid-start counts as a glitch.
                    state_next    = rx_sync_reg ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt_reg == FULL_LAST) begin
                    baud_cnt_next = '0;
                    shift_next    = {rx_sync_reg, shift_reg[7:1]};
                    bit_cnt_next  = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (baud_cnt_reg == FULL_LAST) begin
                    baud_cnt_next = '0;
                    state_next    = STOP;
                    par_fail      = (rx_sync_reg != ^shift_reg);
                end
            end
            STOP: begin
                if (baud_cnt_reg == FULL_LAST) begin
                    baud_cnt_next = '0;
                    state_next    = IDLE;
                    if (!rx_sync_reg)
                        byte_bad = 1'b1;
                    else if (!par_bad_reg)
                        byte_ok = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            rx_meta_reg   <= 1'b1;
            rx_sync_reg   <= 1'b1;
            state_reg     <= IDLE;
            armed_reg     <= 1'b0;
            baud_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            par_bad_reg   <= 1'b0;
            pending_reg   <= 1'b0;
            low_byte_reg  <= '0;
            data_reg      <= '0;
            req_reg       <= 1'b0;
            addr_reg      <= '0;
            word_cnt_reg  <= '0;
            done_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_meta_reg   <= RS232_RX;
            rx_sync_reg   <= rx_meta_reg;
            state_reg     <= state_next;
            armed_reg     <= armed_next;
            baud_cnt_reg  <= baud_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            frame_err_reg <= byte_bad;
            req_reg       <= 1'b0;

            // A parity failure marks the byte bad until the frame ends.
            if (state_reg == IDLE)
                par_bad_reg <= 1'b0;
            else if (par_fail)
                par_bad_reg <= 1'b1;

            // Byte pairing. Any discarded byte restarts the pairing with a low byte.
            if (byte_bad || par_fail) begin
                pending_reg <= 1'b0;
            end else if (byte_ok) begin
                if (!pending_reg) begin
                    low_byte_reg <= shift_reg;
                    pending_reg  <= 1'b1;
                end else begin
                    pending_reg <= 1'b0;
                    if (!done_reg) begin
                        data_reg <= {shift_reg, low_byte_reg};
                        req_reg  <= 1'b1;
                    end
                end
            end

            // The address and word count advance in the cycle after the strobe.
            if (req_reg) begin
                addr_reg     <= addr_reg + 22'd1;
                word_cnt_reg <= word_cnt_reg + 1'b1;
                if (word_cnt_reg == LAST_WORD)
                    done_reg <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err_reg;

    always_ff @(posedge SYSCLK) begin
        if (RST)
            par_err_reg <= 1'b0;
        else
            par_err_reg <= par_fail;
    end

    assign PAR_ERR = par_err_reg;
`else
    assign PAR_ERR = 1'b0;
`endif

    assign WR_FIFO_DATA = data_reg;
    assign WR_FIFO_REQ  = req_reg;
    assign WR_ADDR      = addr_reg;
    assign WR_DONE      = done_reg;
    assign FRAME_ERR    = frame_err_reg;

endmodule
